// File: rtl/hq2x_scan_out.sv
// Output-side line timing for a 2x scaler: locks to the source hblank cadence and
// replays each source line as two output lines with regenerated blank/sync/data-enable.
module hq2x_scan_out #(
  parameter int HALF_DEPTH = 0,
  parameter int HS_OFS     = 8,
  parameter int HS_W       = 16,
  localparam int DWIDTH    = (HALF_DEPTH != 0) ? 11 : 23
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ce_pix2,
  input  logic              hblank_in,
  input  logic              vblank_in,
  input  logic [DWIDTH:0]   outpixel,
  output logic              ce_out,
  output logic [1:0]        read_y,
  output logic              hblank,
  output logic              vblank_out,
  output logic              hs_out,
  output logic              de_out,
  output logic [DWIDTH:0]   pixel_out
);

  localparam logic [12:0] HS_START = 13'(HS_OFS);
  localparam logic [12:0] HS_STOP  = 13'(HS_OFS + HS_W);

  logic              r_ce_out;
  logic              r_hb_prev;
  logic [11:0]       r_cnt;
  logic [11:0]       r_bcnt;
  logic              r_seen;
  logic              r_locked;
  logic              r_par;
  logic              r_line;
  logic              r_done;
  logic [11:0]       r_ocnt;
  logic [11:0]       r_half0;
  logic [11:0]       r_len1;
  logic [11:0]       r_hbh;
  logic              r_vb_src;
  logic              r_hblank;
  logic              r_vblank;
  logic              r_hs;
  logic              r_de;
  logic [DWIDTH:0]   r_pix;

  logic              w_s;
  logic              w_len_ok;
  logic [11:0]       w_cur_len;
  logic              w_locked_n;
  logic              w_par_n;
  logic              w_line_n;
  logic              w_done_n;
  logic [11:0]       w_ocnt_n;
  logic [11:0]       w_half0_n;
  logic [11:0]       w_len1_n;
  logic [11:0]       w_hbh_n;
  logic              w_vb_n;
  logic              w_hb_next;
  logic              w_hs_next;
  logic              w_vblank_next;

  // Lock needs a previous S as reference plus an in-range interval up to this S.
  always_comb begin
    w_s        = ce_pix2 & hblank_in & ~r_hb_prev;
    w_len_ok   = r_seen & (r_cnt >= 12'd16) & (r_cnt != 12'hFFF);
    w_cur_len  = r_line ? r_len1 : r_half0;
    w_locked_n = r_locked;
    w_par_n    = r_par;
    w_line_n   = r_line;
    w_done_n   = r_done;
    w_ocnt_n   = r_ocnt;
    w_half0_n  = r_half0;
    w_len1_n   = r_len1;
    w_hbh_n    = r_hbh;
    w_vb_n     = r_vb_src;
    if (w_s) begin
      w_locked_n = w_len_ok;
      w_vb_n     = vblank_in;
      w_line_n   = 1'b0;
      w_done_n   = 1'b0;
      w_ocnt_n   = 12'd0;
      if (w_len_ok) begin
        w_par_n   = ~r_par;
        w_half0_n = r_cnt >> 1;
        w_len1_n  = r_cnt - (r_cnt >> 1);
        w_hbh_n   = r_bcnt >> 1;
      end else begin
        w_par_n   = 1'b0;
      end
    end else if (ce_pix2 & r_locked & ~r_done) begin
      if (r_ocnt == w_cur_len - 12'd1) begin
        if (!r_line) begin
          w_line_n = 1'b1;
          w_ocnt_n = 12'd0;
        end else begin
          w_done_n = 1'b1;
        end
      end else begin
        w_ocnt_n = r_ocnt + 12'd1;
      end
    end
    w_hb_next     = ~w_locked_n | w_done_n | (w_ocnt_n < w_hbh_n);
    w_hs_next     = w_locked_n & ~w_done_n & ({1'b0, w_ocnt_n} >= HS_START) &
                    ({1'b0, w_ocnt_n} < HS_STOP);
    w_vblank_next = ~w_locked_n | w_vb_n;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hb_prev <= 1'b0;
      r_cnt     <= 12'd0;
      r_bcnt    <= 12'd0;
      r_seen    <= 1'b0;
      r_locked  <= 1'b0;
      r_par     <= 1'b0;
      r_line    <= 1'b0;
      r_done    <= 1'b0;
      r_ocnt    <= 12'd0;
      r_half0   <= 12'd0;
      r_len1    <= 12'd0;
      r_hbh     <= 12'd0;
      r_vb_src  <= 1'b1;
      r_hblank  <= 1'b1;
      r_vblank  <= 1'b1;
      r_hs      <= 1'b0;
    end else if (ce_pix2) begin
      r_hb_prev <= hblank_in;
      if (w_s) begin
        r_cnt  <= 12'd1;
        r_bcnt <= 12'd1;
        r_seen <= 1'b1;
      end else begin
        if (r_cnt != 12'hFFF) r_cnt <= r_cnt + 12'd1;
        if (hblank_in && r_bcnt != 12'hFFF) r_bcnt <= r_bcnt + 12'd1;
      end
      r_locked <= w_locked_n;
      r_par    <= w_par_n;
      r_line   <= w_line_n;
      r_done   <= w_done_n;
      r_ocnt   <= w_ocnt_n;
      r_half0  <= w_half0_n;
      r_len1   <= w_len1_n;
      r_hbh    <= w_hbh_n;
      r_vb_src <= w_vb_n;
      r_hblank <= w_hb_next;
      r_vblank <= w_vblank_next;
      r_hs     <= w_hs_next;
    end
  end

  // Data path runs one clk behind the timing state so it sees the updated blanks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ce_out <= 1'b0;
      r_de     <= 1'b0;
      r_pix    <= '0;
    end else begin
      r_ce_out <= ce_pix2;
      if (r_ce_out) begin
        r_de  <= ~r_hblank & ~r_vblank;
        r_pix <= (~r_hblank & ~r_vblank) ? outpixel : '0;
      end
    end
  end

  assign ce_out     = r_ce_out;
  assign read_y     = {r_par, r_line};
  assign hblank     = r_hblank;
  assign vblank_out = r_vblank;
  assign hs_out     = r_hs;
  assign de_out     = r_de;
  assign pixel_out  = r_pix;

endmodule

// File: tb/tb_hq2x_scan_out.sv
// Directed bench for hq2x_scan_out: source lines are replayed tick by tick and the
// observed output timing is compared against hand-derived line layouts.
module tb_hq2x_scan_out;

  typedef struct packed {
    logic       hb;
    logic       hs;
    logic [1:0] ry;
    logic       vb;
    logic       de;
  } obs_t;

  localparam obs_t UNLK = '{hb: 1'b1, hs: 1'b0, ry: 2'b00, vb: 1'b1, de: 1'b0};
  localparam int   NONE = 100000;

  logic        clk;
  logic        reset_n;
  logic        ce_pix2;
  logic        hblank_in;
  logic        vblank_in;
  logic [23:0] outpixel;
  logic        ce_out;
  logic [1:0]  read_y;
  logic        hblank;
  logic        vblank_out;
  logic        hs_out;
  logic        de_out;
  logic [23:0] pixel_out;

  obs_t        obs_a  [0:4199];
  logic [23:0] obs_px [0:4199];
  int          n_vec;
  int          n_miss;

  hq2x_scan_out dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ce_pix2    (ce_pix2),
    .hblank_in  (hblank_in),
    .vblank_in  (vblank_in),
    .outpixel   (outpixel),
    .ce_out     (ce_out),
    .read_y     (read_y),
    .hblank     (hblank),
    .vblank_out (vblank_out),
    .hs_out     (hs_out),
    .de_out     (de_out),
    .pixel_out  (pixel_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [23:0] pix_of(input int i);
    return 24'(i * 131 + 7) ^ 24'hA50000;
  endfunction

  // Expected output at tick i of a source line, given the output line split in force.
  function automatic obs_t exp_at(input int i, input int half, input int len1, input int hbh,
                                  input logic par, input logic vbo);
    obs_t e;
    int   oc;
    logic ln;
    logic done;
    done = 1'b0;
    if (i < half) begin
      oc = i;
      ln = 1'b0;
    end else if (i < half + len1) begin
      oc = i - half;
      ln = 1'b1;
    end else begin
      oc   = 0;
      ln   = 1'b1;
      done = 1'b1;
    end
    e.hb = done || (oc < hbh);
    e.hs = !done && (oc >= 8) && (oc < 24);
    e.ry = {par, ln};
    e.vb = vbo;
    e.de = !e.hb && !vbo;
    return e;
  endfunction

  // One source line: hblank_in high for ticks [0,b), vblank_in high from vb_from on.
  // Called and returning at a falling clk edge; one ce_pix2 tick every two clocks.
  task automatic run_line(input int len, input int b, input int vb_from);
    for (int i = 0; i < len; i++) begin
      hblank_in = (i < b);
      vblank_in = (i >= vb_from);
      outpixel  = pix_of(i);
      ce_pix2   = 1'b1;
      @(negedge clk);
      ce_pix2   = 1'b0;
      @(negedge clk);
      obs_a[i]  = '{hb: hblank, hs: hs_out, ry: read_y, vb: vblank_out, de: de_out};
      obs_px[i] = pixel_out;
    end
  endtask

  task automatic test_reset;
    reset_n   = 1'b1;
    ce_pix2   = 1'b0;
    hblank_in = 1'b0;
    vblank_in = 1'b0;
    outpixel  = 24'h123456;
    #2 reset_n = 1'b0;
    #1;
    n_vec++;
    if ({ce_out, read_y, hblank, vblank_out, hs_out, de_out} !== 7'b0001100 || pixel_out !== 24'h0) begin
      $display("FAIL reset_state: got ce=%b ry=%b hb=%b vb=%b hs=%b de=%b px=%h, want 0 00 1 1 0 0 000000",
               ce_out, read_y, hblank, vblank_out, hs_out, de_out, pixel_out);
      n_miss++;
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    ce_pix2 = 1'b1;
    @(negedge clk);
    n_vec++;
    if (ce_out !== 1'b1) begin
      $display("FAIL ce_out_follow: got %b want 1", ce_out);
      n_miss++;
    end
    ce_pix2 = 1'b0;
    @(negedge clk);
    n_vec++;
    if (ce_out !== 1'b0) begin
      $display("FAIL ce_out_drop: got %b want 0", ce_out);
      n_miss++;
    end
    // First S after release only sets the reference: still unlocked.
    run_line(800, 160, NONE);
    for (int i = 0; i < 800; i++) begin
      n_vec++;
      if (obs_a[i] !== UNLK || obs_px[i] !== 24'h0) begin
        $display("FAIL unlocked_first_line tick %0d: got {hb,hs,ry,vb,de}=%b px=%h want %b px=0",
                 i, obs_a[i], obs_px[i], UNLK);
        n_miss++;
        break;
      end
    end
  endtask

  task automatic test_steady;
    obs_t e;
    for (int ln = 0; ln < 2; ln++) begin
      run_line(800, 160, NONE);
      for (int i = 0; i < 800; i++) begin
        e = exp_at(i, 400, 400, 80, (ln == 0), 1'b0);
        n_vec++;
        if (obs_a[i] !== e || obs_px[i] !== (e.de ? pix_of(i) : 24'h0)) begin
          $display("FAIL steady line%0d tick %0d: got {hb,hs,ry,vb,de}=%b px=%h want %b px=%h",
                   ln, i, obs_a[i], obs_px[i], e, e.de ? pix_of(i) : 24'h0);
          n_miss++;
          break;
        end
      end
    end
  endtask

  task automatic test_odd_length;
    obs_t e;
    // First 801-tick line still uses the 400/400 split, so tick 800 is a late hold.
    run_line(801, 160, NONE);
    for (int i = 0; i < 801; i++) begin
      e = exp_at(i, 400, 400, 80, 1'b1, 1'b0);
      n_vec++;
      if (obs_a[i] !== e) begin
        $display("FAIL odd_late_hold tick %0d: got %b want %b", i, obs_a[i], e);
        n_miss++;
        break;
      end
    end
    run_line(801, 160, NONE);
    for (int i = 0; i < 801; i++) begin
      e = exp_at(i, 400, 401, 80, 1'b0, 1'b0);
      n_vec++;
      if (obs_a[i] !== e || obs_px[i] !== (e.de ? pix_of(i) : 24'h0)) begin
        $display("FAIL odd_400_401 tick %0d: got %b px=%h want %b", i, obs_a[i], obs_px[i], e);
        n_miss++;
        break;
      end
    end
  endtask

  task automatic test_early_s;
    obs_t e;
    run_line(800, 160, NONE);
    run_line(700, 160, NONE);
    for (int i = 0; i < 700; i++) begin
      e = exp_at(i, 400, 400, 80, 1'b0, 1'b0);
      n_vec++;
      if (obs_a[i] !== e) begin
        $display("FAIL early_truncate tick %0d: got %b want %b", i, obs_a[i], e);
        n_miss++;
        break;
      end
    end
    run_line(700, 160, NONE);
    for (int i = 0; i < 700; i++) begin
      e = exp_at(i, 350, 350, 80, 1'b1, 1'b0);
      n_vec++;
      if (obs_a[i] !== e) begin
        $display("FAIL early_350_350 tick %0d: got %b want %b", i, obs_a[i], e);
        n_miss++;
        break;
      end
    end
  endtask

  task automatic test_vblank;
    obs_t e;
    run_line(800, 160, 300);
    for (int i = 0; i < 800; i++) begin
      e = exp_at(i, 350, 350, 80, 1'b0, 1'b0);
      n_vec++;
      if (obs_a[i] !== e) begin
        $display("FAIL vblank_midline tick %0d: got %b want %b", i, obs_a[i], e);
        n_miss++;
        break;
      end
    end
    run_line(800, 160, 0);
    for (int i = 0; i < 800; i++) begin
      e = exp_at(i, 400, 400, 80, 1'b1, 1'b1);
      n_vec++;
      if (obs_a[i] !== e || obs_px[i] !== 24'h0) begin
        $display("FAIL vblank_active tick %0d: got %b px=%h want %b px=0", i, obs_a[i], obs_px[i], e);
        n_miss++;
        break;
      end
    end
    run_line(800, 160, NONE);
    for (int i = 0; i < 800; i++) begin
      e = exp_at(i, 400, 400, 80, 1'b0, 1'b0);
      n_vec++;
      if (obs_a[i] !== e || obs_px[i] !== (e.de ? pix_of(i) : 24'h0)) begin
        $display("FAIL vblank_release tick %0d: got %b px=%h want %b", i, obs_a[i], obs_px[i], e);
        n_miss++;
        break;
      end
    end
  endtask

  task automatic test_lock_loss;
    obs_t e;
    run_line(4200, 160, NONE);
    for (int i = 0; i < 4200; i++) begin
      e = exp_at(i, 400, 400, 80, 1'b1, 1'b0);
      n_vec++;
      if (obs_a[i] !== e) begin
        $display("FAIL long_line tick %0d: got %b want %b", i, obs_a[i], e);
        n_miss++;
        break;
      end
    end
    run_line(800, 160, NONE);
    for (int i = 0; i < 800; i++) begin
      n_vec++;
      if (obs_a[i] !== UNLK || obs_px[i] !== 24'h0) begin
        $display("FAIL lock_dropped tick %0d: got %b px=%h want %b", i, obs_a[i], obs_px[i], UNLK);
        n_miss++;
        break;
      end
    end
    run_line(800, 160, NONE);
    for (int i = 0; i < 800; i++) begin
      e = exp_at(i, 400, 400, 80, 1'b1, 1'b0);
      n_vec++;
      if (obs_a[i] !== e) begin
        $display("FAIL relock tick %0d: got %b want %b", i, obs_a[i], e);
        n_miss++;
        break;
      end
    end
  endtask

  task automatic test_reset_midline;
    obs_t e;
    run_line(201, 160, NONE);
    n_vec++;
    if (obs_a[200] !== exp_at(200, 400, 400, 80, 1'b0, 1'b0)) begin
      $display("FAIL pre_reset tick 200: got %b want %b", obs_a[200], exp_at(200, 400, 400, 80, 1'b0, 1'b0));
      n_miss++;
    end
    #2 reset_n = 1'b0;
    #1;
    n_vec++;
    if ({ce_out, read_y, hblank, vblank_out, hs_out, de_out} !== 7'b0001100 || pixel_out !== 24'h0) begin
      $display("FAIL midline_reset: got ce=%b ry=%b hb=%b vb=%b hs=%b de=%b px=%h, want 0 00 1 1 0 0 000000",
               ce_out, read_y, hblank, vblank_out, hs_out, de_out, pixel_out);
      n_miss++;
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    run_line(800, 160, NONE);
    for (int i = 0; i < 800; i++) begin
      n_vec++;
      if (obs_a[i] !== UNLK) begin
        $display("FAIL post_reset_unlocked tick %0d: got %b want %b", i, obs_a[i], UNLK);
        n_miss++;
        break;
      end
    end
    run_line(800, 160, NONE);
    for (int i = 0; i < 800; i++) begin
      e = exp_at(i, 400, 400, 80, 1'b1, 1'b0);
      n_vec++;
      if (obs_a[i] !== e || obs_px[i] !== (e.de ? pix_of(i) : 24'h0)) begin
        $display("FAIL post_reset_relock tick %0d: got %b px=%h want %b", i, obs_a[i], obs_px[i], e);
        n_miss++;
        break;
      end
    end
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    test_reset;
    test_steady;
    test_odd_length;
    test_early_s;
    test_vblank;
    test_lock_loss;
    test_reset_midline;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
